ctrl_pipe: RTL and testbench

//  Parametrised decode->writeback control-word pipeline; replaces hand-built per-stage control flops.

---
 rtl/ctrl_pipe_pkg.sv | 12 +
 rtl/ctrl_pipe_stage.sv | 38 +++
 rtl/ctrl_pipe.sv | 70 +++++++
 tb/tb_ctrl_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared limits, control-bundle field offsets and stage update encoding
package ctrl_pipe_pkg;
  localparam int MAX_STAGES = 8;
  localparam int MAX_W = 64;
  localparam int ALU_OR_MEM_BIT = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int REGDST_BIT = 2;
  localparam int RW_BIT = 3;
  localparam int ALUCONTROL_LSB = 4;
  localparam int ALUCONTROL_W = 3;
  typedef enum logic [1:0] {OP_LOAD, OP_HOLD, OP_BUBBLE, OP_FLUSH} stage_op_e;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one valid+control register with flush > hold > bubble > load priority
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic         valid_i,
  input  logic [W-1:0] ctrl_i,
  output logic         valid_o,
  output logic [W-1:0] ctrl_o
);
  stage_op_e op;
  logic valid_d, valid_q;
  logic [W-1:0] ctrl_d, ctrl_q;
  // pick the update rule; an invalid incoming word loads as all-zero control
  always_comb begin
    op = flush_i ? OP_FLUSH : hold_i ? OP_HOLD : bubble_i ? OP_BUBBLE : OP_LOAD;
    valid_d = op == OP_HOLD ? valid_q : op == OP_LOAD ? valid_i : 1'b0;
    ctrl_d = op == OP_HOLD ? ctrl_q : (op == OP_LOAD && valid_i) ? ctrl_i : '0;
  end
  // stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign valid_o = valid_q;
  assign ctrl_o = ctrl_q;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline with stall-derived hold and bubbles; CTRL_PIPE_PERF_EN adds bubble/stall counters
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int W = 36,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_ctrl,
  output logic                  in_ready,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  output logic [STAGES-1:0]     stage_valid,
  output logic [STAGES*W-1:0]   stage_ctrl,
  output logic                  retire,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);
  if (STAGES < 2 || STAGES > MAX_STAGES || W < 1 || W > MAX_W) begin : g_bad_param
    $error("ctrl_pipe: illegal STAGES/W");
  end
  logic [STAGES-1:0] hold, up_valid, up_hold;
  logic [STAGES*W-1:0] up_ctrl;
  // a stall freezes its own stage and every stage upstream of it
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) hold[k] = |(stall >> k);
  end
  assign up_valid = {stage_valid[STAGES-2:0], in_valid};
  assign up_ctrl = {stage_ctrl[(STAGES-1)*W-1:0], in_ctrl};
  assign up_hold = {hold[STAGES-2:0], 1'b0};
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ctrl_pipe_stage #(.W(W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush[i]),
      .hold_i  (hold[i]),
      .bubble_i(up_hold[i]),
      .valid_i (up_valid[i]),
      .ctrl_i  (up_ctrl[i*W +: W]),
      .valid_o (stage_valid[i]),
      .ctrl_o  (stage_ctrl[i*W +: W])
    );
  end
  assign in_ready = ~hold[0];
  assign retire = stage_valid[STAGES-1] & ~hold[STAGES-1];
`ifdef CTRL_PIPE_PERF_EN
  logic bubble_ev;
  logic [CNT_W-1:0] bubble_cnt_q, stall_cnt_q;
  assign bubble_ev = |(~flush[STAGES-1:1] & ~hold[STAGES-1:1] & hold[STAGES-2:0] & stage_valid[STAGES-2:0]);
  // saturating counters: bubbles that displaced a valid word, and cycles stage 0 was held
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bubble_ev && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      if (hold[0] && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign bubble_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random stimulus against a rule-level pipeline model with a retire scoreboard
module tb_ctrl_pipe;
  localparam int S = 3;
  localparam int W = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, retire;
  logic [W-1:0] in_ctrl = '0;
  logic [S-1:0] stall = '0, flush = '0, stage_valid;
  logic [S*W-1:0] stage_ctrl;
  logic [CW-1:0] bubble_cnt, stall_cnt;
  int total = 0, bad = 0, cyc = 0;
  bit mon_en = 0;
  logic mv[S];
  logic [W-1:0] mc[S];
  logic [CW-1:0] mb = '0, ms = '0;
  int stamp_q[$];
  logic [W-1:0] data_q[$];

  ctrl_pipe #(.STAGES(S), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ready(in_ready),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .retire(retire), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < S; i++) begin mv[i] = 0; mc[i] = '0; end

  function automatic bit held(input int i, input logic [S-1:0] st);
    for (int j = i; j < S; j++) if (st[j]) return 1;
    return 0;
  endfunction

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  // reference model: apply the per-stage rules top-down so each stage sees its upstream's old value
  always @(posedge clk) begin : model
    bit ev;
    ev = 0;
    if (reset) begin
      for (int i = 0; i < S; i++) begin mv[i] = 0; mc[i] = '0; end
      mb = '0;
      ms = '0;
    end else begin
      for (int i = S - 1; i >= 0; i--) begin
        if (flush[i]) begin mv[i] = 0; mc[i] = '0; end
        else if (held(i, stall)) begin end
        else if (i > 0 && held(i - 1, stall)) begin
          if (mv[i-1]) ev = 1;
          mv[i] = 0;
          mc[i] = '0;
        end else if (i == 0) begin
          mv[0] = in_valid;
          mc[0] = in_valid ? in_ctrl : '0;
        end else begin
          mv[i] = mv[i-1];
          mc[i] = mc[i-1];
        end
      end
      if (ev && mb != CMAX) mb++;
      if (held(0, stall) && ms != CMAX) ms++;
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] c, input logic [S-1:0] st, input logic [S-1:0] fl);
    @(posedge clk);
    #1;
    reset = r; in_valid = v; in_ctrl = c; stall = st; flush = fl;
    cyc++;
    if (mv[S-1] && !held(S-1, st)) begin
      stamp_q.push_back(cyc);
      data_q.push_back(mc[S-1]);
    end
  endtask

  // monitor: compare visible state each cycle and pop the scoreboard on every retirement
  always @(negedge clk) if (mon_en) begin : monitor
    logic [S-1:0] ev;
    logic [S*W-1:0] ec;
    int st;
    logic [W-1:0] d;
    for (int i = 0; i < S; i++) begin ev[i] = mv[i]; ec[i*W +: W] = mc[i]; end
    check("in_ready", in_ready, !held(0, stall));
    check("stage_valid", stage_valid, ev);
    check("stage_ctrl", stage_ctrl, ec);
    check("retire", retire, mv[S-1] && !held(S-1, stall));
`ifdef CTRL_PIPE_PERF_EN
    check("bubble_cnt", bubble_cnt, mb);
    check("stall_cnt", stall_cnt, ms);
`else
    check("bubble_cnt", bubble_cnt, 0);
    check("stall_cnt", stall_cnt, 0);
`endif
    if (retire) begin
      if (stamp_q.size() == 0) check("retire_unexpected", {56'd0, stage_ctrl[(S-1)*W +: W]}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        st = stamp_q.pop_front();
        d = data_q.pop_front();
        check("retire_cycle", st, cyc);
        check("retire_word", stage_ctrl[(S-1)*W +: W], d);
      end
    end else if (stamp_q.size() != 0 && stamp_q[0] == cyc) begin
      st = stamp_q.pop_front();
      d = data_q.pop_front();
      check("retire_missing", 0, 1);
    end
  end

  initial begin
    step(1, 0, 0, 0, 0);
    mon_en = 1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_ready", in_ready, 1);
    check("reset_valid", stage_valid, 0);
    // plain stream: 0x11 reaches stage 2 at the third edge
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("stream_s2", stage_ctrl[2*W +: W], 8'h11);
    check("stream_retire", retire, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    // stall stage 1 with 0x22/0x11 in stages 0/1
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 3'b010, 0);
    @(negedge clk);
    check("stall_ready", in_ready, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_s1", stage_ctrl[W +: W], 8'h11);
    check("stall_bubble_v", stage_valid[2], 0);
    check("stall_bubble_c", stage_ctrl[2*W +: W], 0);
    repeat (3) step(0, 0, 0, 0, 0);
    // flush stage 0 while it is stalled
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 0, 0, 3'b001, 3'b001);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_valid", stage_valid, 3'b100);
    repeat (3) step(0, 0, 0, 0, 0);
    // reset with three words in flight
    step(0, 1, 8'hA1, 0, 0);
    step(0, 1, 8'hA2, 0, 0);
    step(0, 1, 8'hA3, 0, 0);
    step(1, 0, 0, 3'b111, 3'b010);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_valid", stage_valid, 0);
    check("rst_ctrl", stage_ctrl, 0);
    check("rst_retire", retire, 0);
    // long stall on stage 0
    repeat (20) step(0, 1, 8'h5A, 3'b001, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef CTRL_PIPE_PERF_EN
    check("stall_sat", stall_cnt, 4'hF);
`else
    check("stall_off", stall_cnt, 0);
`endif
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [S-1:0] st, fl;
      for (int i = 0; i < S; i++) begin
        st[i] = $urandom_range(0, 4) == 0;
        fl[i] = $urandom_range(0, 19) == 0;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, W'($urandom), st, fl);
    end
    repeat (S + 4) step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("drain_empty", stamp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
